// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and parameter-legality checks for sync_fifo_flagged.
package sync_fifo_pkg;

    // Address bits needed to index DEPTH entries.
    function automatic int unsigned addr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Pointer width: address bits plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Count width: must represent 0..DEPTH inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // True when v is a nonzero power of two.
    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    // Full legality check of the FIFO parameter set.
    function automatic bit params_legal(
        input int unsigned width,
        input int unsigned depth,
        input int unsigned af_level,
        input int unsigned ae_level
    );
        bit ok;
        ok = 1'b1;
        if (width < 1)                            ok = 1'b0;
        if (depth < 4)                            ok = 1'b0;
        if (!is_pow2(depth))                      ok = 1'b0;
        if (af_level < 1 || af_level > depth - 1) ok = 1'b0;
        if (ae_level < 1 || ae_level > depth - 1) ok = 1'b0;
        if (ae_level >= af_level)                 ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/sync_fifo_flagged_if.sv
// Handshake, data and status bundle between a FIFO user (master) and the FIFO (slave).
interface sync_fifo_flagged_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
);
    import sync_fifo_pkg::*;

    localparam int unsigned CW = count_width(DEPTH);

    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             ready;
    logic [CW-1:0]    count;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    // FIFO user side: drives requests, observes data and status.
    modport master (
        output wr_en, data_in, rd_en,
        input  data_out, valid, ready, count,
        input  almost_full, almost_empty, overflow, underflow
    );

    // FIFO side: observes requests, drives data and status.
    modport slave (
        input  wr_en, data_in, rd_en,
        output data_out, valid, ready, count,
        output almost_full, almost_empty, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_ptr.sv
// FIFO pointer with an extra wrap bit; the wrap bit toggles each time the
// address field rolls over from DEPTH-1 to 0.
module sync_fifo_ptr
    import sync_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned PW    = ptr_width(DEPTH),
    localparam int unsigned AW    = addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [PW-1:0] ptr,
    output logic [AW-1:0] addr
);

    logic [PW-1:0] ptr_q;

    // Advance on inc; DEPTH is a power of two so natural overflow gives the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (inc) begin
            ptr_q <= ptr_q + PW'(1);
        end
    end

    assign ptr  = ptr_q;
    assign addr = ptr_q[AW-1:0];

endmodule

// File: rtl/sync_fifo_flagged.sv
// Synchronous FIFO with count register, almost-full/empty decodes and sticky
// overflow/underflow flags. Read mode selected by macro SYNC_FIFO_FWFT_EN:
// defined = first-word-fall-through, undefined = registered read data.
module sync_fifo_flagged
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input logic                clk,
    input logic                rst,
    sync_fifo_flagged_if.slave bus
);

    localparam int unsigned AW = addr_width(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = count_width(DEPTH);

    // Refuse to elaborate an illegal parameter set.
    if (!params_legal(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_illegal_params
        $error("sync_fifo_flagged: illegal parameters WIDTH=%0d DEPTH=%0d AF_LEVEL=%0d AE_LEVEL=%0d",
               WIDTH, DEPTH, AF_LEVEL, AE_LEVEL);
    end

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          underflow_q;
    logic          not_empty;
    logic          not_full;
    logic          wr_accept;
    logic          rd_accept;

    // Wrap bits are kept for debug visibility; occupancy comes from count_q only.
    logic unused_wrap;
    assign unused_wrap = ^{wptr[PW-1], rptr[PW-1]};

    // Status decodes of the count register.
    assign not_empty = (count_q != '0);
    assign not_full  = (count_q != CW'(DEPTH));

    // Accept logic; reset blocks both operations in the same cycle.
    assign wr_accept = bus.wr_en && not_full  && !rst;
    assign rd_accept = bus.rd_en && not_empty && !rst;

    sync_fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
        .clk  (clk),
        .rst  (rst),
        .inc  (wr_accept),
        .ptr  (wptr),
        .addr (waddr)
    );

    sync_fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
        .clk  (clk),
        .rst  (rst),
        .inc  (rd_accept),
        .ptr  (rptr),
        .addr (raddr)
    );

    // Storage write; memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[waddr] <= bus.data_in;
        end
    end

    // Occupancy counter: +1 write only, -1 read only, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            case ({wr_accept, rd_accept})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wr_en && !not_full) begin
                overflow_q <= 1'b1;
            end
            if (bus.rd_en && !not_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented directly whenever the FIFO holds data.
    assign bus.data_out = mem[raddr];
`else
    logic [WIDTH-1:0] data_q;

    // Read data loads on the accepting edge and holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (rd_accept) begin
            data_q <= mem[raddr];
        end
    end

    assign bus.data_out = data_q;
`endif

    assign bus.count        = count_q;
    assign bus.valid        = not_empty;
    assign bus.ready        = not_full;
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
